// File: rtl/spi_tx_queue_pkg.sv
// rtl/spi_tx_queue_pkg.sv - shared defaults and FSM encoding for the SPI transmit queue
//
// Holds the byte width, timing defaults and FSM state encoding that the
// queue shares with the SPI master it feeds.
package spi_tx_queue_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_GAP_CYCLES = 2;
    localparam int SPI_TIMEOUT    = 1023;

    // 2-bit FSM state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/spi_tx_queue_fifo.sv
// rtl/spi_tx_queue_fifo.sv - synchronous circular-buffer FIFO used by the SPI transmit queue
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write request and data (ignored while full)
//   pop                read request (ignored while empty)
//   head_data          entry at the read pointer
//   full, empty        occupancy flags, derived from the registered level
//   level              current occupancy, 0..DEPTH
module spi_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spi_tx_queue.sv
// rtl/spi_tx_queue.sv - byte queue that paces transfers into an SPI master
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_valid/      byte input; a push happens when in_valid and
//   in_ready               in_ready are high at a rising edge
//   m_start, m_data        one-cycle start pulse and byte for the master
//   m_done                 master completion pulse
//   busy                   FSM active or bytes still queued
//   level                  queue occupancy
//   timeout_err            one-cycle pulse when a transfer is abandoned
module spi_tx_queue
    import spi_tx_queue_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = SPI_GAP_CYCLES,
    parameter int TIMEOUT    = SPI_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   m_start,
    output logic [DATA_WIDTH-1:0]  m_data,
    input  logic                   m_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout_err
);

    localparam int WD_W = (TIMEOUT >= 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GP_W = (GAP_CYCLES >= 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);
    // A zero gap still spends one cycle in GAP so the FSM stays simple.
    localparam logic [GP_W-1:0] GAP_LAST = GP_W'((GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0);

    logic [1:0]            state_q, state_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [GP_W-1:0]       gap_q, gap_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  fifo_pop;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    spi_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (in_valid),
        .push_data  (in_data),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (level)
    );

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        m_data_d    = m_data_q;
        fifo_pop    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Capture the head on the way into LOAD so m_data is stable
                // for the whole start cycle.
                if (!fifo_empty) begin
                    state_d  = ST_LOAD;
                    m_data_d = fifo_head;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_DONE;
                wd_d    = '0;
            end
            ST_WAIT_DONE: begin
                // The byte stays queued until the master finishes or the
                // watchdog gives up; either way it is then dropped.
                if (m_done) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_GAP;
                    gap_d    = '0;
                end else if (wd_q == WD_MAX) begin
                    fifo_pop    = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = ST_GAP;
                    gap_d       = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + GP_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wd_q     <= '0;
            gap_q    <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            m_data_q <= m_data_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign m_start     = (state_q == ST_LOAD);
    assign m_data      = m_data_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_spi_tx_queue.sv
// tb/tb_spi_tx_queue.sv - randomized self-checking bench for spi_tx_queue
module tb_spi_tx_queue;

    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 1023;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [DW-1:0]          in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   m_start;
    logic [DW-1:0]          m_data;
    logic                   m_done;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   timeout_err;

    spi_tx_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .m_start     (m_start),
        .m_data      (m_data),
        .m_done      (m_done),
        .busy        (busy),
        .level       (level),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a byte queue plus the timing rules of a transfer.
    logic [DW-1:0] q[$];
    bit            act;          // a byte has been started and is not yet retired
    int            start_cyc;    // cycle in which m_start is expected
    int            idle_from;    // first cycle after the inter-transfer gap
    int            done_delay;   // cycles after start at which the master answers; <=0 never
    logic [DW-1:0] exp_mdata;
    int            cyc;
    int            fixed_delay;  // >0 fixed response delay, 0 random
    bit            spur_en;      // inject m_done where it must be ignored
    bit            to_byte_en;   // byte 0x77 never gets an answer
    int            model_starts = 0;
    int            dut_starts   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        act       = 1'b0;
        start_cyc = -100000;
        idle_from = 0;
        exp_mdata = '0;
    endtask

    function automatic bit model_busy();
        return act || (cyc < idle_from) || (q.size() != 0);
    endfunction

    task automatic check_outputs();
        bit exp_start;
        bit exp_to;
        exp_start = act && (cyc == start_cyc);
        exp_to    = act && (cyc == start_cyc + 1 + TIMEOUT) && !m_done;
        if (m_start) dut_starts++;
        check("m_start", 32'(m_start), 32'(exp_start));
        check("m_data", 32'(m_data), 32'(exp_mdata));
        check("level", 32'(level), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        check("busy", 32'(busy), 32'(model_busy()));
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_m_start", 32'(m_start), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
    endtask

    // Apply the inputs of cycle 'cyc' to the model at the closing edge.
    task automatic model_edge();
        int sz;
        bit start_now;
        bit pop_now;
        sz        = q.size();
        start_now = !act && (cyc >= idle_from) && (sz != 0);
        pop_now   = act && (cyc > start_cyc) &&
                    (m_done || (cyc == start_cyc + 1 + TIMEOUT));
        if (pop_now) begin
            void'(q.pop_front());
            act       = 1'b0;
            idle_from = cyc + 1 + GAP;
        end
        if (in_valid && sz != DEPTH) q.push_back(in_data);
        if (start_now) begin
            exp_mdata = q[0];
            act       = 1'b1;
            start_cyc = cyc + 1;
            model_starts++;
            if (to_byte_en && q[0] == 8'h77) done_delay = -1;
            else if (fixed_delay > 0)        done_delay = fixed_delay;
            else                             done_delay = $urandom_range(1, 60);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic run_cycle(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_data  = d;
        m_done   = 1'b0;
        if (act && done_delay > 0 && cyc == start_cyc + done_delay)
            m_done = 1'b1;
        else if (spur_en && (!act || cyc == start_cyc) && $urandom_range(0, 7) == 0)
            m_done = 1'b1;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && model_busy(); i++) run_cycle(1'b0, '0);
        #1;
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        m_done      = 1'b0;
        cyc         = 0;
        fixed_delay = 0;
        spur_en     = 1'b0;
        to_byte_en  = 1'b0;
        done_delay  = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Single byte, answered 50 cycles after its start.
        fixed_delay = 50;
        run_cycle(1'b1, 8'h35);
        drain(500);

        // Fill the queue, then keep pushing while full so the push that
        // coincides with a pop is refused and the following one accepted.
        fixed_delay = 40;
        run_cycle(1'b1, 8'h35);
        run_cycle(1'b1, 8'h44);
        run_cycle(1'b1, 8'hA5);
        run_cycle(1'b1, 8'h0F);
        for (int i = 0; i < 60; i++) run_cycle(1'b1, 8'h99);
        drain(1000);

        // Unanswered byte is abandoned by the watchdog; the next one follows.
        to_byte_en  = 1'b1;
        fixed_delay = 10;
        run_cycle(1'b1, 8'h77);
        run_cycle(1'b1, 8'h12);
        drain(3000);
        to_byte_en = 1'b0;

        // Reset while waiting on the master with three bytes still queued.
        fixed_delay = 100;
        run_cycle(1'b1, 8'hA1);
        run_cycle(1'b1, 8'hA2);
        run_cycle(1'b1, 8'hA3);
        run_cycle(1'b1, 8'hA4);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, '0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_done   = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) run_cycle(1'b0, '0);
        fixed_delay = 5;
        run_cycle(1'b1, 8'h5A);
        drain(500);

        // Random traffic with random response delays and ignored m_done pulses.
        fixed_delay = 0;
        spur_en     = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) run_cycle(1'b1, DW'($urandom));
            else                           run_cycle(1'b0, DW'($urandom));
        end
        drain(3000);
        spur_en = 1'b0;

        check("start_count", 32'(dut_starts), 32'(model_starts));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_tx_queue.md
SPI_TX_QUEUE -- requirements
Module: spi_tx_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the byte width and matches the SPI master data width.
REQ-002 Parameter DEPTH, default 4 (power of 2, ≥2), is the number of queue entries.
REQ-003 Parameter GAP_CYCLES, default 2, is the idle clk cycles between a master done and the next start.
REQ-004 Parameter TIMEOUT, default 1023, is the max clk cycles to wait for m_done before aborting a transfer.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_data  in  DATA_WIDTH  byte to transmit.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  queue can accept; a push occurs when in_valid and in_ready are both high at a clk edge.
REQ-010 m_start  out  1  one-cycle start pulse to the SPI master.
REQ-011 m_data  out  DATA_WIDTH  byte presented to the master's data_in.
REQ-012 m_done  in  1  master done (one-cycle pulse).
REQ-013 busy  out  1  high when the FSM is not IDLE or the queue is non-empty.
REQ-014 level  out  $clog2(DEPTH)+1  current queue occupancy.
REQ-015 timeout_err  out  1  one-cycle pulse when a transfer is aborted.

Function
REQ-016 FIFO: circular buffer with wrapping read/write pointers and an occupancy counter; in_ready = (level != DEPTH), registered-derived.
REQ-017 FSM states: IDLE, LOAD, WAIT_DONE, GAP; state is registered.
REQ-018 IDLE -> LOAD when level != 0; otherwise stay in IDLE.
REQ-019 On entry to LOAD, m_data is registered from the FIFO head; m_start = (state==LOAD) for exactly one cycle; LOAD -> WAIT_DONE unconditionally.
REQ-020 m_data holds its value from LOAD until the next LOAD, including through GAP and IDLE.
REQ-021 WAIT_DONE: on m_done=1, pop the head and go to GAP.
REQ-022 WAIT_DONE: a watchdog counts cycles; at count==TIMEOUT without m_done, pop the head, pulse timeout_err, and go to GAP.
REQ-023 GAP: count GAP_CYCLES cycles, then go to IDLE; m_done received in GAP, LOAD or IDLE is ignored.
REQ-024 Latency: a push into an empty queue in IDLE at edge k makes m_start high in the cycle following edge k+1.
REQ-025 Back-to-back: the next m_start occurs GAP_CYCLES+2 cycles after the cycle in which m_done is seen, if the queue is non-empty.
REQ-026 A simultaneous push and pop updates both pointers, leaves level unchanged, and keeps ordering.
REQ-027 in_valid while full is not accepted: in_ready=0, and data and pointers are unchanged.
REQ-028 Bytes are emitted in strict FIFO order; pointers wrap modulo DEPTH.
REQ-029 level never exceeds DEPTH and never underflows; a pop only occurs from WAIT_DONE with level ≥1.

Reset
REQ-030 rst_n=0 forces state=IDLE, pointers=0, level=0, and clears the watchdog and gap counters, asynchronously.
REQ-031 Output reset values: in_ready=1, m_start=0, m_data=0, busy=0, level=0, timeout_err=0.
REQ-032 Reset mid-transfer discards all queued bytes; there is no m_done expectation after release.
REQ-033 FIFO storage array is not reset.

Structure
REQ-034 A shared package holds DATA_WIDTH default, FSM state encoding (2-bit), and TIMEOUT/GAP defaults used with the SPI master.
REQ-035 The FIFO is one sub-module, spi_sync_fifo (push/pop/full/empty/level), instantiated once.
REQ-036 The FSM, watchdog, and gap counter reside in spi_tx_queue.

Verification
REQ-037 Push 0x35 into an empty queue -> m_start is one cycle wide at k+2, m_data=0x35; m_done after 50 cycles -> level 0, busy falls after GAP.
REQ-038 Push 0x35, 0x44, 0xA5, 0x0F back-to-back -> level=4, in_ready=0; a 5th push is ignored; starts occur in order 0x35, 0x44, 0xA5, 0x0F, each spaced GAP_CYCLES+2 after its m_done.
REQ-039 Full queue with a push in the same cycle as m_done pop -> that push is still rejected (in_ready=0 at that edge); the next push after the pop is accepted and level returns to 4.
REQ-040 Never assert m_done after a start of 0x77 -> timeout_err pulses at TIMEOUT cycles, 0x77 is dropped, and the next byte starts after GAP.
REQ-041 Assert rst_n=0 during WAIT_DONE with 3 bytes queued -> all outputs take reset values immediately; after release there is no m_start until a new push.
REQ-042 Perform 2*DEPTH+1 push/transfer cycles -> pointer wrap occurs with no lost or duplicated byte (scoreboard).
